// File: rtl/c2c_stream_tgen_chk.sv
// ---------------------------------------------------------------------------
// c2c_stream_tgen_chk
//
// Traffic generator and checker for the 2-lane Aurora chip-to-chip link,
// running in the Aurora user_clk domain.
//
// The generator drives the Aurora TX user interface with numbered frames of
// FRAME_LEN beats. Every 32-bit lane of a beat carries {frame[15:0], beat[15:0]}.
// The checker hunts for the first beat of a frame on the RX user interface,
// locks onto its frame number and then verifies every following beat.
//
// Ports:
//   aclk, aresetn        user clock, synchronous active-low reset
//   channel_up           Aurora channel status; low aborts TX and unlocks RX
//   tx_enable            generator runs while high (the current frame always completes)
//   clear_counters       one-cycle pulse, zeroes all counters
//   m_axis_tx_*          AXI4-Stream master towards the Aurora TX user port
//   s_axis_rx_*          AXI4-Stream slave from the Aurora RX user port (no tready)
//   frames_tx            completed TX frames (saturating)
//   frames_rx            RX frames checked error-free (saturating)
//   err_count            errored RX beats (saturating)
//   locked               checker is tracking the frame pattern
// ---------------------------------------------------------------------------
module c2c_stream_tgen_chk #(
    parameter int DATA_W     = 128,
    parameter int FRAME_LEN  = 256,
    parameter int GAP_CYCLES = 4
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              channel_up,
    input  logic              tx_enable,
    input  logic              clear_counters,
    output logic [DATA_W-1:0] m_axis_tx_tdata,
    output logic              m_axis_tx_tvalid,
    output logic              m_axis_tx_tlast,
    input  logic              m_axis_tx_tready,
    input  logic [DATA_W-1:0] s_axis_rx_tdata,
    input  logic              s_axis_rx_tvalid,
    input  logic              s_axis_rx_tlast,
    output logic [31:0]       frames_tx,
    output logic [31:0]       frames_rx,
    output logic [31:0]       err_count,
    output logic              locked
);

    localparam int              NUM_LANES = DATA_W / 32;
    localparam logic [15:0]     LAST_BEAT = 16'(FRAME_LEN - 1);
    localparam int              GAP_W     = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_SEND,
        TX_GAP
    } txState_t;

    typedef enum logic {
        RX_HUNT,
        RX_CHECK
    } rxState_t;

    txState_t         r_txState;
    logic             r_txValid;
    logic [15:0]      r_txFrame;
    logic [15:0]      r_txBeat;
    logic [GAP_W-1:0] r_gapCnt;

    rxState_t         r_rxState;
    logic             r_locked;
    logic [15:0]      r_rxFrame;
    logic [15:0]      r_rxBeat;

    logic [31:0]      r_framesTx;
    logic [31:0]      r_framesRx;
    logic [31:0]      r_errCount;

    logic             w_txFrameDone;
    logic             w_lanesEqual;
    logic             w_lanesMatch;
    logic             w_rxBeat;
    logic             w_rxLast;
    logic             w_rxGood;
    logic             w_lockBeat;
    logic             w_rxErr;
    logic             w_rxFrameDone;

    // Lanes are replicated straight from the frame/beat registers, so the data
    // cannot change while a beat is stalled waiting for tready.
    assign m_axis_tx_tdata  = {NUM_LANES{r_txFrame, r_txBeat}};
    assign m_axis_tx_tvalid = r_txValid;
    assign m_axis_tx_tlast  = r_txValid & (r_txBeat == LAST_BEAT);

    // A handshake in a cycle where channel_up is low does not count: the frame
    // is aborted and resent with the same frame number.
    assign w_txFrameDone = r_txValid & m_axis_tx_tready & channel_up & (r_txBeat == LAST_BEAT);

    // Generator: IDLE waits for enable, SEND walks the beats of one frame,
    // GAP inserts GAP_CYCLES idle cycles before the next frame.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_txState <= TX_IDLE;
            r_txValid <= 1'b0;
            r_txFrame <= '0;
            r_txBeat  <= '0;
            r_gapCnt  <= '0;
        end else if (!channel_up) begin
            r_txState <= TX_IDLE;
            r_txValid <= 1'b0;
            r_txBeat  <= '0;
            r_gapCnt  <= '0;
        end else begin
            case (r_txState)
                TX_IDLE: begin
                    if (tx_enable) begin
                        r_txState <= TX_SEND;
                        r_txValid <= 1'b1;
                    end
                end
                TX_SEND: begin
                    if (m_axis_tx_tready) begin
                        if (r_txBeat == LAST_BEAT) begin
                            r_txBeat  <= '0;
                            r_txFrame <= r_txFrame + 16'd1;
                            if (GAP_CYCLES > 0) begin
                                r_txState <= TX_GAP;
                                r_txValid <= 1'b0;
                                r_gapCnt  <= GAP_LOAD;
                            end else if (tx_enable) begin
                                r_txState <= TX_SEND;
                                r_txValid <= 1'b1;
                            end else begin
                                r_txState <= TX_IDLE;
                                r_txValid <= 1'b0;
                            end
                        end else begin
                            r_txBeat <= r_txBeat + 16'd1;
                        end
                    end
                end
                TX_GAP: begin
                    if (r_gapCnt == '0) begin
                        if (tx_enable) begin
                            r_txState <= TX_SEND;
                            r_txValid <= 1'b1;
                        end else begin
                            r_txState <= TX_IDLE;
                        end
                    end else begin
                        r_gapCnt <= r_gapCnt - GAP_W'(1);
                    end
                end
                default: begin
                    r_txState <= TX_IDLE;
                    r_txValid <= 1'b0;
                end
            endcase
        end
    end

    // Lane comparison: equality with lane 0 is what HUNT needs to find a frame
    // start, a match against the expected word is what CHECK needs.
    always_comb begin
        w_lanesEqual = 1'b1;
        w_lanesMatch = 1'b1;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (s_axis_rx_tdata[i*32 +: 32] != s_axis_rx_tdata[31:0]) begin
                w_lanesEqual = 1'b0;
            end
            if (s_axis_rx_tdata[i*32 +: 32] != {r_rxFrame, r_rxBeat}) begin
                w_lanesMatch = 1'b0;
            end
        end
    end

    assign w_rxBeat      = s_axis_rx_tvalid & channel_up;
    assign w_rxLast      = (r_rxBeat == LAST_BEAT);
    assign w_rxGood      = w_lanesMatch & (s_axis_rx_tlast == w_rxLast);
    assign w_lockBeat    = (r_rxState == RX_HUNT) & w_rxBeat & w_lanesEqual &
                           (s_axis_rx_tdata[15:0] == 16'd0);
    assign w_rxErr       = (r_rxState == RX_CHECK) & w_rxBeat & ~w_rxGood;
    assign w_rxFrameDone = (r_rxState == RX_CHECK) & w_rxBeat & w_rxGood & w_rxLast;

    // Checker: lock on a beat-0 word, then expect beat 1 of the same frame.
    // Any bad beat drops back to HUNT so a single error is counted once.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_rxState <= RX_HUNT;
            r_locked  <= 1'b0;
            r_rxFrame <= '0;
            r_rxBeat  <= '0;
        end else if (!channel_up) begin
            r_rxState <= RX_HUNT;
            r_locked  <= 1'b0;
        end else if (w_lockBeat) begin
            r_rxState <= RX_CHECK;
            r_locked  <= 1'b1;
            r_rxFrame <= s_axis_rx_tdata[31:16];
            r_rxBeat  <= 16'd1;
        end else if (w_rxErr) begin
            r_rxState <= RX_HUNT;
            r_locked  <= 1'b0;
        end else if ((r_rxState == RX_CHECK) && w_rxBeat) begin
            if (w_rxLast) begin
                r_rxFrame <= r_rxFrame + 16'd1;
                r_rxBeat  <= '0;
            end else begin
                r_rxBeat <= r_rxBeat + 16'd1;
            end
        end
    end

    // Saturating statistics counters; a clear pulse wins over an increment
    // in the same cycle.
    always_ff @(posedge aclk) begin
        if (!aresetn || clear_counters) begin
            r_framesTx <= '0;
            r_framesRx <= '0;
            r_errCount <= '0;
        end else begin
            if (w_txFrameDone && (r_framesTx != '1)) begin
                r_framesTx <= r_framesTx + 32'd1;
            end
            if (w_rxFrameDone && (r_framesRx != '1)) begin
                r_framesRx <= r_framesRx + 32'd1;
            end
            if (w_rxErr && (r_errCount != '1)) begin
                r_errCount <= r_errCount + 32'd1;
            end
        end
    end

    assign frames_tx = r_framesTx;
    assign frames_rx = r_framesRx;
    assign err_count = r_errCount;
    assign locked    = r_locked;

endmodule

// File: tb/tb_c2c_stream_tgen_chk.sv
// ---------------------------------------------------------------------------
// tb_c2c_stream_tgen_chk
//
// Bench for c2c_stream_tgen_chk with FRAME_LEN=4, GAP_CYCLES=2, DATA_W=128.
// TX is looped back into RX (only accepted beats are forwarded), with optional
// corruption of one beat or removal of tlast on one frame. A monitor records
// every accepted TX beat; a frame-counting reference model derives the
// expected word for each beat and the expected frame totals.
// ---------------------------------------------------------------------------
module tb_c2c_stream_tgen_chk;

    localparam int DATA_W     = 128;
    localparam int FRAME_LEN  = 4;
    localparam int GAP_CYCLES = 2;
    localparam int NL         = DATA_W / 32;
    localparam logic [DATA_W-1:0] INJ_MASK = DATA_W'(1) << 37;

    logic              aclk = 1'b0;
    logic              aresetn = 1'b0;
    logic              channel_up = 1'b0;
    logic              tx_enable = 1'b0;
    logic              clear_counters = 1'b0;
    logic [DATA_W-1:0] tx_tdata;
    logic              tx_tvalid;
    logic              tx_tlast;
    logic              tx_tready = 1'b1;
    logic [DATA_W-1:0] rx_tdata;
    logic              rx_tvalid;
    logic              rx_tlast;
    logic [31:0]       frames_tx;
    logic [31:0]       frames_rx;
    logic [31:0]       err_count;
    logic              locked;

    logic              injectOn = 1'b0;
    logic [15:0]       injF = 16'd0;
    logic [15:0]       injB = 16'd0;
    logic              dropLastOn = 1'b0;
    logic [15:0]       dropF = 16'd0;
    logic              useRand = 1'b0;

    int testsRun = 0;
    int testsFailed = 0;

    typedef struct {
        logic              abort;
        logic [DATA_W-1:0] data;
        logic              last;
        logic              lockAfter;
        logic [31:0]       errAfter;
    } entry_t;

    entry_t            monQ[$];
    entry_t            hsQ[$];
    entry_t            pend;
    entry_t            abortE;
    bit                pendValid = 1'b0;
    bit                stallPrev = 1'b0;
    logic [DATA_W-1:0] stallData;
    int                stallViol = 0;
    logic [DATA_W-1:0] afterAbortData;

    always #5 aclk = ~aclk;

    c2c_stream_tgen_chk #(
        .DATA_W     (DATA_W),
        .FRAME_LEN  (FRAME_LEN),
        .GAP_CYCLES (GAP_CYCLES)
    ) dut (
        .aclk             (aclk),
        .aresetn          (aresetn),
        .channel_up       (channel_up),
        .tx_enable        (tx_enable),
        .clear_counters   (clear_counters),
        .m_axis_tx_tdata  (tx_tdata),
        .m_axis_tx_tvalid (tx_tvalid),
        .m_axis_tx_tlast  (tx_tlast),
        .m_axis_tx_tready (tx_tready),
        .s_axis_rx_tdata  (rx_tdata),
        .s_axis_rx_tvalid (rx_tvalid),
        .s_axis_rx_tlast  (rx_tlast),
        .frames_tx        (frames_tx),
        .frames_rx        (frames_rx),
        .err_count        (err_count),
        .locked           (locked)
    );

    // Loopback path with fault injection on a chosen frame/beat.
    assign rx_tvalid = tx_tvalid & tx_tready & channel_up;
    assign rx_tdata  = tx_tdata ^ ((injectOn && (tx_tdata[31:0] == {injF, injB})) ? INJ_MASK : '0);
    assign rx_tlast  = tx_tlast & ~(dropLastOn && (tx_tdata[31:16] == dropF));

    // Monitor: records accepted TX beats together with the checker status
    // seen one cycle later, marks channel drops, and watches stalled beats.
    always @(negedge aclk) begin
        if (pendValid) begin
            pend.lockAfter = locked;
            pend.errAfter  = err_count;
            monQ.push_back(pend);
            pendValid = 1'b0;
        end
        if (aresetn) begin
            if (!channel_up) begin
                abortE.abort     = 1'b1;
                abortE.data      = '0;
                abortE.last      = 1'b0;
                abortE.lockAfter = 1'b0;
                abortE.errAfter  = '0;
                monQ.push_back(abortE);
            end else if (tx_tvalid && tx_tready) begin
                pend.abort = 1'b0;
                pend.data  = tx_tdata;
                pend.last  = tx_tlast;
                pendValid  = 1'b1;
            end
            if (stallPrev && channel_up && ((tx_tvalid !== 1'b1) || (tx_tdata !== stallData))) begin
                stallViol++;
            end
        end
        stallPrev = aresetn && channel_up && tx_tvalid && !tx_tready;
        stallData = tx_tdata;
    end

    // Advance one clock; inputs change 1 ns after the active edge.
    task automatic tick();
        @(posedge aclk);
        #1;
        tx_tready = useRand ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    task automatic runCycles(input int n);
        repeat (n) tick();
    endtask

    task automatic doReset();
        aresetn        = 1'b0;
        channel_up     = 1'b1;
        tx_enable      = 1'b0;
        clear_counters = 1'b0;
        injectOn       = 1'b0;
        dropLastOn     = 1'b0;
        useRand        = 1'b0;
        runCycles(3);
        monQ.delete();
        hsQ.delete();
        pendValid = 1'b0;
        stallViol = 0;
        aresetn   = 1'b1;
    endtask

    task automatic drain();
        tx_enable = 1'b0;
        runCycles(60);
        useRand = 1'b0;
        runCycles(4);
    endtask

    // Reference model: beats are numbered per frame, FRAME_LEN beats make a
    // frame, and a channel drop restarts the current frame at beat 0.
    task automatic processStream(output int bad, output int frames);
        int                f;
        int                b;
        bit                sawAbort;
        bit                gotAfter;
        logic [DATA_W-1:0] expWord;
        bad = 0;
        frames = 0;
        f = 0;
        b = 0;
        sawAbort = 1'b0;
        gotAfter = 1'b0;
        afterAbortData = '1;
        hsQ.delete();
        foreach (monQ[i]) begin
            if (monQ[i].abort) begin
                b = 0;
                sawAbort = 1'b1;
            end else begin
                expWord = {NL{f[15:0], b[15:0]}};
                if ((monQ[i].data !== expWord) || (monQ[i].last !== (b == FRAME_LEN - 1))) begin
                    bad++;
                end
                if (sawAbort && !gotAfter) begin
                    afterAbortData = monQ[i].data;
                    gotAfter = 1'b1;
                end
                hsQ.push_back(monQ[i]);
                b++;
                if (b == FRAME_LEN) begin
                    b = 0;
                    f = (f + 1) % 65536;
                    frames++;
                end
            end
        end
        monQ.delete();
    endtask

    task automatic test_reset();
        doReset();
        @(negedge aclk);
        testsRun++;
        if (tx_tvalid !== 1'b0 || tx_tlast !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_valid: got tvalid=%b tlast=%b expected 0 0", tx_tvalid, tx_tlast);
        end
        testsRun++;
        if (tx_tdata !== '0) begin
            testsFailed++;
            $display("[TB] FAIL reset_tdata: got %h expected 0", tx_tdata);
        end
        testsRun++;
        if (frames_tx !== 32'd0 || frames_rx !== 32'd0 || err_count !== 32'd0) begin
            testsFailed++;
            $display("[TB] FAIL reset_counters: got %0d/%0d/%0d expected 0/0/0", frames_tx, frames_rx, err_count);
        end
        testsRun++;
        if (locked !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_locked: got %b expected 0", locked);
        end
    endtask

    task automatic test_loopback();
        int bad;
        int frames;
        doReset();
        tx_enable = 1'b1;
        runCycles(40);
        drain();
        processStream(bad, frames);
        testsRun++;
        if (bad !== 0) begin
            testsFailed++;
            $display("[TB] FAIL loop_stream: got %0d bad beats expected 0", bad);
        end
        testsRun++;
        if (frames !== 7) begin
            testsFailed++;
            $display("[TB] FAIL loop_frame_count: got %0d frames expected 7", frames);
        end
        testsRun++;
        if (hsQ.size() < 4 || hsQ[0].data !== '0 || hsQ[0].last !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL loop_beat0: got %h expected 0", hsQ[0].data);
        end
        testsRun++;
        if (hsQ.size() < 4 || hsQ[3].data !== {NL{32'h0000_0003}} || hsQ[3].last !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL loop_beat3: got %h last=%b expected %h last=1",
                     hsQ[3].data, hsQ[3].last, {NL{32'h0000_0003}});
        end
        testsRun++;
        if (hsQ.size() < 1 || hsQ[0].lockAfter !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL loop_locked: got %b after first beat expected 1", hsQ[0].lockAfter);
        end
        testsRun++;
        if (frames_tx !== 32'(frames) || frames_rx !== 32'(frames) || err_count !== 32'd0) begin
            testsFailed++;
            $display("[TB] FAIL loop_counters: got tx=%0d rx=%0d err=%0d expected %0d/%0d/0",
                     frames_tx, frames_rx, err_count, frames, frames);
        end
    endtask

    task automatic test_random_ready();
        int bad;
        int frames;
        doReset();
        useRand = 1'b1;
        tx_enable = 1'b1;
        runCycles(80);
        drain();
        processStream(bad, frames);
        testsRun++;
        if (stallViol !== 0) begin
            testsFailed++;
            $display("[TB] FAIL rand_stable: got %0d unstable stalled beats expected 0", stallViol);
        end
        testsRun++;
        if (bad !== 0) begin
            testsFailed++;
            $display("[TB] FAIL rand_stream: got %0d bad beats expected 0", bad);
        end
        testsRun++;
        if (hsQ.size() < 7 || hsQ[6].data !== {NL{32'h0001_0002}}) begin
            testsFailed++;
            $display("[TB] FAIL rand_f1b2: got %h expected %h", hsQ[6].data, {NL{32'h0001_0002}});
        end
        testsRun++;
        if (frames_tx !== 32'(frames) || frames_rx !== 32'(frames) || err_count !== 32'd0) begin
            testsFailed++;
            $display("[TB] FAIL rand_counters: got tx=%0d rx=%0d err=%0d expected %0d/%0d/0",
                     frames_tx, frames_rx, err_count, frames, frames);
        end
    endtask

    task automatic test_bit_error();
        int bad;
        int frames;
        doReset();
        injectOn = 1'b1;
        injF = 16'd2;
        injB = 16'd1;
        tx_enable = 1'b1;
        runCycles(60);
        drain();
        processStream(bad, frames);
        testsRun++;
        if (hsQ.size() < 13 || hsQ[8].errAfter !== 32'd0 || hsQ[9].errAfter !== 32'd1) begin
            testsFailed++;
            $display("[TB] FAIL err_timing: got %0d then %0d expected 0 then 1", hsQ[8].errAfter, hsQ[9].errAfter);
        end
        testsRun++;
        if (hsQ[9].lockAfter !== 1'b0 || hsQ[11].lockAfter !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL err_unlock: got %b %b expected 0 0", hsQ[9].lockAfter, hsQ[11].lockAfter);
        end
        testsRun++;
        if (hsQ[12].lockAfter !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL err_relock: got %b at frame 3 beat 0 expected 1", hsQ[12].lockAfter);
        end
        testsRun++;
        if (err_count !== 32'd1 || frames_rx !== 32'(frames - 1) || frames_tx !== 32'(frames)) begin
            testsFailed++;
            $display("[TB] FAIL err_counters: got err=%0d rx=%0d tx=%0d expected 1/%0d/%0d",
                     err_count, frames_rx, frames_tx, frames - 1, frames);
        end
    endtask

    task automatic test_channel_drop();
        int   bad;
        int   frames;
        bit   found;
        logic validAfter;
        logic [31:0] framesAtDrop;
        doReset();
        tx_enable = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            tick();
            if (tx_tvalid && tx_tdata[31:0] == 32'h0005_0002) found = 1'b1;
        end
        channel_up = 1'b0;
        tick();
        @(negedge aclk);
        validAfter = tx_tvalid;
        framesAtDrop = frames_tx;
        runCycles(3);
        channel_up = 1'b1;
        runCycles(40);
        drain();
        processStream(bad, frames);
        testsRun++;
        if (!found || validAfter !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL drop_tvalid: found=%0d got tvalid=%b expected 0", found, validAfter);
        end
        testsRun++;
        if (framesAtDrop !== 32'd5) begin
            testsFailed++;
            $display("[TB] FAIL drop_frames_at_drop: got %0d expected 5", framesAtDrop);
        end
        testsRun++;
        if (afterAbortData !== {NL{32'h0005_0000}}) begin
            testsFailed++;
            $display("[TB] FAIL drop_restart: got %h expected %h", afterAbortData, {NL{32'h0005_0000}});
        end
        testsRun++;
        if (bad !== 0) begin
            testsFailed++;
            $display("[TB] FAIL drop_stream: got %0d bad beats expected 0", bad);
        end
        testsRun++;
        if (frames_tx !== 32'(frames) || frames_rx !== 32'(frames) || err_count !== 32'd0) begin
            testsFailed++;
            $display("[TB] FAIL drop_counters: got tx=%0d rx=%0d err=%0d expected %0d/%0d/0",
                     frames_tx, frames_rx, err_count, frames, frames);
        end
    endtask

    task automatic test_missing_tlast();
        int bad;
        int frames;
        doReset();
        dropLastOn = 1'b1;
        dropF = 16'd1;
        tx_enable = 1'b1;
        runCycles(40);
        drain();
        processStream(bad, frames);
        testsRun++;
        if (hsQ.size() < 9 || hsQ[7].errAfter !== 32'd1 || hsQ[7].lockAfter !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL tlast_error: got err=%0d locked=%b expected 1 0", hsQ[7].errAfter, hsQ[7].lockAfter);
        end
        testsRun++;
        if (hsQ[8].lockAfter !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL tlast_relock: got %b expected 1", hsQ[8].lockAfter);
        end
        testsRun++;
        if (err_count !== 32'd1 || frames_rx !== 32'(frames - 1)) begin
            testsFailed++;
            $display("[TB] FAIL tlast_counters: got err=%0d rx=%0d expected 1/%0d", err_count, frames_rx, frames - 1);
        end
    endtask

    task automatic test_saturation();
        int bad;
        int frames;
        doReset();
        @(negedge aclk);
        force dut.r_errCount = 32'hFFFF_FFFF;
        #1;
        release dut.r_errCount;
        dropLastOn = 1'b1;
        dropF = 16'd1;
        tx_enable = 1'b1;
        runCycles(40);
        drain();
        processStream(bad, frames);
        testsRun++;
        if (err_count !== 32'hFFFF_FFFF) begin
            testsFailed++;
            $display("[TB] FAIL sat_err: got %h expected ffffffff", err_count);
        end
        clear_counters = 1'b1;
        tick();
        clear_counters = 1'b0;
        @(negedge aclk);
        testsRun++;
        if (err_count !== 32'd0 || frames_tx !== 32'd0 || frames_rx !== 32'd0) begin
            testsFailed++;
            $display("[TB] FAIL sat_clear: got %0d/%0d/%0d expected 0/0/0", err_count, frames_tx, frames_rx);
        end
    endtask

    task automatic test_clear_on_completion();
        int bad;
        int frames;
        bit found;
        doReset();
        tx_enable = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            tick();
            if (tx_tvalid && tx_tready && tx_tlast && tx_tdata[31:16] == 16'd2) found = 1'b1;
        end
        clear_counters = 1'b1;
        tick();
        clear_counters = 1'b0;
        @(negedge aclk);
        testsRun++;
        if (!found || frames_tx !== 32'd0 || frames_rx !== 32'd0 || err_count !== 32'd0) begin
            testsFailed++;
            $display("[TB] FAIL clear_same_cycle: found=%0d got %0d/%0d/%0d expected 0/0/0",
                     found, frames_tx, frames_rx, err_count);
        end
        testsRun++;
        if (locked !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL clear_keeps_lock: got %b expected 1", locked);
        end
        runCycles(30);
        drain();
        processStream(bad, frames);
        testsRun++;
        if (frames_tx !== 32'(frames - 3) || frames_rx !== 32'(frames - 3)) begin
            testsFailed++;
            $display("[TB] FAIL clear_resume: got tx=%0d rx=%0d expected %0d", frames_tx, frames_rx, frames - 3);
        end
    endtask

    task automatic test_reset_midframe();
        int bad;
        int frames;
        bit found;
        doReset();
        tx_enable = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            tick();
            if (tx_tvalid && tx_tdata[31:0] == 32'h0002_0001) found = 1'b1;
        end
        aresetn = 1'b0;
        tick();
        testsRun++;
        if (!found || tx_tvalid !== 1'b0 || tx_tlast !== 1'b0 || frames_tx !== 32'd0 || locked !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL midreset_state: found=%0d got tvalid=%b tlast=%b tx=%0d locked=%b expected 0",
                     found, tx_tvalid, tx_tlast, frames_tx, locked);
        end
        monQ.delete();
        pendValid = 1'b0;
        aresetn = 1'b1;
        runCycles(30);
        drain();
        processStream(bad, frames);
        testsRun++;
        if (bad !== 0 || frames_tx !== 32'(frames) || frames_rx !== 32'(frames)) begin
            testsFailed++;
            $display("[TB] FAIL midreset_restart: got bad=%0d tx=%0d rx=%0d expected 0/%0d/%0d",
                     bad, frames_tx, frames_rx, frames, frames);
        end
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_random_ready();
        test_bit_error();
        test_channel_drop();
        test_missing_tlast();
        test_saturation();
        test_clear_on_completion();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] timeout");
    end

endmodule
